// File: rtl/crg_pkg.sv
// Shared CRG definitions: clock-gate controller states, default windows and counter sizing.
package crg_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_IDLE  = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } cg_state_t;

  localparam int unsigned CG_IDLE_DEFAULT = 16;
  localparam int unsigned CG_WAKE_DEFAULT = 2;

  // Width able to hold the larger of the two windows
  function automatic int unsigned cg_cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/crg_down_cnt.sv
// Loadable down-counter that saturates at zero; shared with the CRG reset sequencer.
module crg_down_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; decrement stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cg_enable_ctrl.sv
// Idle-detect enable controller for a CRG clock-gate cell.
// Optional FORCE_ON override compiled in with `define CG_FORCE_ON_EN.
module cg_enable_ctrl
  import crg_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = CG_IDLE_DEFAULT,
  parameter int unsigned WAKE_CYCLES = CG_WAKE_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic ACTIVE,
  input  logic SLEEP_REQ,
  input  logic WAKE_REQ,
`ifdef CG_FORCE_ON_EN
  input  logic FORCE_ON,
`endif
  output logic EN,
  output logic GATED,
  output logic WAKE_DONE
);

  localparam int unsigned CNT_W = cg_cnt_width(IDLE_CYCLES, WAKE_CYCLES);

  cg_state_t        state_q;
  cg_state_t        state_nx;
  logic             force_on;
  logic             qual;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             wake_done_nx;

`ifdef CG_FORCE_ON_EN
  assign force_on = FORCE_ON;
`else
  assign force_on = 1'b0;
`endif

  // Any wake source makes the cycle non-qualifying, so wake always beats sleep
  assign qual = SLEEP_REQ & ~ACTIVE & ~WAKE_REQ & ~force_on;

  crg_down_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, counter control and next output values
  always_comb begin
    state_nx     = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    wake_done_nx = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (qual) begin
          state_nx     = S_IDLE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(IDLE_CYCLES - 1);
        end
      end
      S_IDLE: begin
        if (!qual) begin
          state_nx = S_RUN;
        end else if (cnt_zero) begin
          state_nx = S_GATED;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_GATED: begin
        if (!qual) begin
          state_nx     = S_WAKE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(WAKE_CYCLES - 1);
        end
      end
      S_WAKE: begin
        if (cnt_zero) begin
          state_nx     = S_RUN;
          wake_done_nx = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  // Outputs follow the post-edge state so EN only moves on rising CLK
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_RUN;
      EN        <= 1'b1;
      GATED     <= 1'b0;
      WAKE_DONE <= 1'b0;
    end else begin
      state_q   <= state_nx;
      EN        <= (state_nx != S_GATED);
      GATED     <= (state_nx == S_GATED);
      WAKE_DONE <= wake_done_nx;
    end
  end

endmodule
